// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier.
// Optional feature macro: ABORT_EN (adds an Abort input to mul8_seq).
package mul8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  // Controller states; the unused code 2'd3 is handled as IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Iteration counter value on the edge that performs the final step.
  localparam logic [2:0] ITER_LAST = 3'd7;

endpackage

// File: rtl/mul8_bit8adder.sv
// BIT8ADDER: 8-bit ripple-carry adder shared by all multiply iterations.
// Only the carry out is brought out; signed overflow has no use in an
// unsigned multiplier and is not generated.
module mul8_bit8adder
  import mul8_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum,
  output logic            cout
);

  logic carry;

  // Ripple the carry bit by bit from the LSB.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < OP_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  assign cout = carry;

endmodule

// File: rtl/mul8_dp.sv
// Multiplier datapath: multiplicand M, partial high Acc, multiplier /
// partial low Q, the shared adder and the combined add-then-shift step.
// The adder carry only lives inside a step: after the right shift the
// carry position is always zero, so it is not held in a register.
module mul8_dp
  import mul8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product_next
);

  logic [OP_W-1:0] m;
  logic [OP_W-1:0] acc;
  logic [OP_W-1:0] q;
  logic [OP_W-1:0] add_sum;
  logic            add_cout;
  logic [OP_W:0]   sum_post;    // {C, Acc} after the conditional add
  logic [PROD_W:0] shifted;     // {C, Acc, Q} after the shift
  logic [OP_W-1:0] acc_next;
  logic [OP_W-1:0] q_next;

  mul8_bit8adder u_adder (
    .a    (acc),
    .b    (m),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One iteration: add M when Q[0] is set, then shift {C,Acc,Q} right.
  always_comb begin
    sum_post     = q[0] ? {add_cout, add_sum} : {1'b0, acc};
    shifted      = {1'b0, sum_post, q[OP_W-1:1]};
    acc_next     = shifted[PROD_W-1:OP_W];
    q_next       = shifted[OP_W-1:0];
    product_next = {acc_next, q_next};
  end

  // Operand capture on accept, iteration update while stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      acc <= '0;
      q   <= '0;
    end else if (load) begin
      m   <= a;
      acc <= '0;
      q   <= b;
    end else if (step) begin
      acc <= acc_next;
      q   <= q_next;
    end
  end

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier controller with Start/Busy/Done
// handshake. Optional macro ABORT_EN adds an Abort input that cancels a
// multiply in progress.
//
// Handshake: Start is sampled only in IDLE; the edge that samples it
// captures A/B. Busy is high in RUN and DONE. Done is a one-cycle pulse
// in which P holds the new product; P then holds until the next
// completion. Start during Busy is dropped, never queued.
module mul8_seq
  import mul8_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
`ifdef ABORT_EN
  input  logic              Abort,
`endif
  output logic              Busy,
  output logic              Done,
  output logic [PROD_W-1:0] P,
  output logic [1:0]        dbg_state
);

  state_e            state;
  state_e            state_next;
  logic [2:0]        cnt;
  logic              load;
  logic              step;
  logic              last;
  logic [PROD_W-1:0] product_next;

  mul8_dp u_dp (
    .clk          (Clock),
    .rst_n        (Reset),
    .load         (load),
    .step         (step),
    .a            (A),
    .b            (B),
    .product_next (product_next)
  );

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_RUN: begin
        Busy = 1'b1;
`ifdef ABORT_EN
        if (Abort) begin
          state_next = S_IDLE;
        end else
`endif
        begin
          step = 1'b1;
          if (cnt == ITER_LAST) begin
            last       = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        if (Start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Iteration counter: cleared on accept, advanced on every step.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 3'd1;
  end

  // Product register, written only by the final iteration.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    P <= '0;
    else if (last) P <= product_next;
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed testbench for mul8_seq. Build with +define+ABORT_EN to also
// exercise the abort path.
module tb_mul8_seq;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
`ifdef ABORT_EN
  logic        Abort;
`endif
  logic        Busy;
  logic        Done;
  logic [15:0] P;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  mul8_seq dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .A         (A),
    .B         (B),
`ifdef ABORT_EN
    .Abort     (Abort),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .P         (P),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One complete multiply; expected product comes from the scoreboard queue.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string tag);
    logic [15:0] p_exp;
    int early;
    exp_q.push_back(exp);
    A = a; B = b; Start = 1'b1;
    tick();                                   // E0
    Start = 1'b0;
`ifdef ABORT_EN
    Abort = 1'b0;
`endif
    A = 8'($urandom_range(0, 255));
    B = 8'($urandom_range(0, 255));
    check({tag, "_busy_e0"}, Busy, 1);
    check({tag, "_state_e0"}, dbg_state, 2'd1);
    early = 0;
    repeat (7) begin                          // E1..E7
      tick();
      if (Done || !Busy) early++;
    end
    check({tag, "_early_done"}, early, 0);
    tick();                                   // E8
    p_exp = exp_q.pop_front();
    check({tag, "_done_e8"}, Done, 1);
    check({tag, "_p"}, P, p_exp);
    tick();                                   // E9
    check({tag, "_busy_e9"}, Busy, 0);
    check({tag, "_done_e9"}, Done, 0);
    check({tag, "_p_hold"}, P, p_exp);
  endtask

  initial begin
    int ndone;
    int npass;
    Reset = 1'b0; Start = 1'b0; A = 8'h00; B = 8'h00;
`ifdef ABORT_EN
    Abort = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_p", P, 16'h0000);
    check("rst_state", dbg_state, 2'd0);
    Reset = 1'b1;
    tick();

    run_mul(8'h0F, 8'h11, 16'h00FF, "m0f11");

    // FF x FF with Start re-pulsed in RUN and in DONE.
    A = 8'hFF; B = 8'hFF; Start = 1'b1;
    tick();                                   // E0
    Start = 1'b0;
    tick(); tick();                           // E1, E2
    A = 8'h02; B = 8'h03; Start = 1'b1;
    tick();                                   // E3
    Start = 1'b0;
    ndone = 0;
    repeat (4) begin                          // E4..E7
      tick();
      if (Done) ndone++;
    end
    check("ff_no_early_done", ndone, 0);
    tick();                                   // E8
    check("ff_done", Done, 1);
    check("ff_p", P, 16'hFE01);
    A = 8'h02; B = 8'h03; Start = 1'b1;
    tick();                                   // E9: Start seen in DONE
    Start = 1'b0;
    check("ff_busy_e9", Busy, 0);
    tick(); tick();
    check("ff_ignored_busy", Busy, 0);
    check("ff_ignored_done", Done, 0);
    check("ff_ignored_p", P, 16'hFE01);

    run_mul(8'h00, 8'h5A, 16'h0000, "m005a");

    // Start held: one accept per 10 cycles.
    A = 8'h10; B = 8'h10; Start = 1'b1;
    ndone = 0; npass = 0;
    repeat (30) begin
      tick();
      if (Done) begin
        ndone++;
        if (P == 16'h0100) npass++;
      end
    end
    Start = 1'b0;
    check("held_done_cnt", ndone, 3);
    check("held_p_ok", npass, 3);
    check("held_p", P, 16'h0100);
    repeat (12) tick();
    check("held_idle", Busy, 0);

    // Reset asserted mid-operation.
    A = 8'h07; B = 8'h09; Start = 1'b1;
    tick();                                   // E0
    Start = 1'b0;
    repeat (4) tick();                        // E1..E4
    check("mid_busy_pre", Busy, 1);
    Reset = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_p", P, 16'h0000);
    tick();
    Reset = 1'b1;
    tick();
    run_mul(8'h07, 8'h09, 16'h003F, "m0709");

`ifdef ABORT_EN
    // Abort at E5: back to IDLE, no Done, P keeps 003F.
    A = 8'h0C; B = 8'h0A; Start = 1'b1;
    tick();                                   // E0
    Start = 1'b0;
    repeat (4) tick();                        // E1..E4
    Abort = 1'b1;
    tick();                                   // E5
    Abort = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_state", dbg_state, 2'd0);
    check("abort_p", P, 16'h003F);
    ndone = 0;
    repeat (10) begin
      tick();
      if (Done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    // Abort together with Start in IDLE: Start wins.
    Abort = 1'b1;
    run_mul(8'h0C, 8'h0A, 16'h0078, "m0c0a");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
